// File: rtl/mmio_pkg.sv
// Shared addresses, FSM state type and STATUS bit positions for the
// memory-mapped UART transmitter.
package mmio_pkg;

  localparam logic [31:0] UART_DATA_ADDR   = 32'hffff_0040;
  localparam logic [31:0] UART_STATUS_ADDR = 32'hffff_0044;
  localparam logic [31:0] UART_ACK_ADDR    = 32'hffff_0048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_PENDING   = 4;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/byte_fifo.sv
// Small circular FIFO with occupancy count; a push while full is refused,
// a pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // Fullness is judged before this cycle's pop, so a push into a full FIFO is dropped.
  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 transmitter on the data bus: decodes DATA/STATUS/ACK,
// queues bytes, serializes them and raises a level interrupt when drained.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        UartInterrupt,
  output logic        UartAddress,
  output logic [31:0] uart_rd_data,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  tx_state_t             state_q, state_d;
  logic [CW-1:0]         clkCnt_q, clkCnt_d;
  logic [2:0]            bitCnt_q, bitCnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  pending_q, pending_d;
  logic                  overflow_q, overflow_d;

  logic                  hitData, hitStatus, hitAck;
  logic                  pushReq, ackWr, bitTick, setPending, fifoPop;
  logic                  fifoFull, fifoEmpty;
  logic [7:0]            fifoHead;
  logic [$clog2(DEPTH):0] fifoCount;
  logic [31:0]           status;
  logic                  unusedData;

  assign hitData     = (address == UART_DATA_ADDR);
  assign hitStatus   = (address == UART_STATUS_ADDR);
  assign hitAck      = (address == UART_ACK_ADDR);
  assign UartAddress = hitData || hitStatus || hitAck;
  assign pushReq     = MemWrite && hitData;
  assign ackWr       = MemWrite && hitAck;
  assign unusedData  = ^data[31:8];

  byte_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (pushReq),
    .wdata_i (data[7:0]),
    .pop_i   (fifoPop),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = (state_q != IDLE);
    status[STAT_EMPTY]              = fifoEmpty;
    status[STAT_FULL]               = fifoFull;
    status[STAT_OVERFLOW]           = overflow_q;
    status[STAT_PENDING]            = pending_q;
    status[STAT_COUNT_LSB +: 8]     = 8'(fifoCount);
  end

  assign uart_rd_data  = (MemRead && hitStatus) ? status : 32'd0;
  assign bitTick       = (clkCnt_q == LAST_TICK);
  assign txd           = txd_q;
  assign UartInterrupt = pending_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifoEmpty) state_d = START;
      START:   if (bitTick) state_d = DATA;
      DATA:    if (bitTick && bitCnt_q == 3'd7) state_d = STOP;
      STOP:    if (bitTick) state_d = fifoEmpty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // STOP chains straight into the next START when more bytes wait, so frames abut.
  always_comb begin
    fifoPop    = 1'b0;
    setPending = 1'b0;
    clkCnt_d   = clkCnt_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE: begin
        clkCnt_d = '0;
        bitCnt_d = '0;
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoHead;
        end
      end
      START: begin
        clkCnt_d = bitTick ? '0 : clkCnt_q + 1'b1;
      end
      DATA: begin
        clkCnt_d = bitTick ? '0 : clkCnt_q + 1'b1;
        if (bitTick) begin
          shift_d  = shift_q >> 1;
          bitCnt_d = bitCnt_q + 1'b1;
        end
      end
      STOP: begin
        clkCnt_d = bitTick ? '0 : clkCnt_q + 1'b1;
        if (bitTick) begin
          bitCnt_d = '0;
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            shift_d = fifoHead;
          end else begin
            setPending = 1'b1;
          end
        end
      end
      default: begin
        clkCnt_d = '0;
        bitCnt_d = '0;
      end
    endcase
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // A completing frame outranks a same-edge ACK for pending; ACK always clears overflow.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (setPending) begin
      pending_d = 1'b1;
    end else if (ackWr) begin
      pending_d = 1'b0;
    end
    if (ackWr) begin
      overflow_d = 1'b0;
    end else if (pushReq && fifoFull) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkCnt_q   <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      clkCnt_q   <= clkCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: queued bytes are decoded back off txd
// and compared, plus status, decode, interrupt and reset behaviour.
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] A_DATA   = 32'hffff_0040;
  localparam logic [31:0] A_STATUS = 32'hffff_0044;
  localparam logic [31:0] A_ACK    = 32'hffff_0048;

  logic        clk = 1'b0;
  logic        reset;
  logic        UartInterrupt;
  logic        UartAddress;
  logic [31:0] uart_rd_data;
  logic [31:0] address;
  logic [31:0] data;
  logic        MemRead;
  logic        MemWrite;
  logic        txd;

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;
  int frameCount = 0;
  int frameStart[$];
  logic [7:0] expQ[$];

  mmio_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .UartInterrupt (UartInterrupt),
    .UartAddress   (UartAddress),
    .uart_rd_data  (uart_rd_data),
    .address       (address),
    .data          (data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .txd           (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Decodes every frame off txd at falling edges and checks it against the scoreboard.
  logic [9:0] monBits;
  bit         monStable;
  bit         monAbort;
  int         monStart;
  logic [7:0] monExp;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && txd === 1'b0) begin
        monBits   = '0;
        monStable = 1'b1;
        monAbort  = 1'b0;
        monStart  = cycleCnt;
        for (int s = 1; s < FRAME; s++) begin
          @(negedge clk);
          if (reset !== 1'b1) monAbort = 1'b1;
          if (s % CPB == 0) monBits[s / CPB] = txd;
          else if (txd !== monBits[s / CPB]) monStable = 1'b0;
        end
        if (!monAbort) begin
          compared++;
          frameCount++;
          frameStart.push_back(monStart);
          if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL frame: observed unexpected frame %b, required no frame", monBits);
          end else begin
            monExp = expQ.pop_front();
            if (!monStable || monBits !== {1'b1, monExp, 1'b0}) begin
              mismatched++;
              $display("[TB] FAIL frame: observed %b stable=%0d, required %b",
                       monBits, monStable, {1'b1, monExp, 1'b0});
            end
          end
        end
      end
    end
  end

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] value);
    address  = addr;
    data     = value;
    MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    address  = '0;
    data     = '0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] value);
    address = addr;
    MemRead = 1'b1;
    #1;
    value   = uart_rd_data;
    MemRead = 1'b0;
    address = '0;
  endtask

  task automatic test_reset();
    logic [31:0] st;
    reset    = 1'b0;
    address  = '0;
    data     = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (txd !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_txd: observed %b, required 1", txd);
    end
    compared++;
    if (UartInterrupt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_irq: observed %b, required 0", UartInterrupt);
    end
    busRead(A_STATUS, st);
    compared++;
    if (st !== 32'h0000_0002) begin
      mismatched++;
      $display("[TB] FAIL reset_status: observed %h, required 00000002", st);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int cnt;
    int base;
    base = frameCount;
    expQ.push_back(8'hA5);
    busWrite(A_DATA, 32'hFFFF_FFA5);
    compared++;
    if (txd !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL latency_idle: observed txd %b, required 1", txd);
    end
    @(negedge clk);
    compared++;
    if (txd !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL latency_start: observed txd %b, required 0", txd);
    end
    cnt = 0;
    while (UartInterrupt !== 1'b1 && cnt < FRAME + 20) begin
      @(negedge clk);
      cnt++;
    end
    compared++;
    if (cnt != FRAME) begin
      mismatched++;
      $display("[TB] FAIL single_irq_time: observed %0d cycles, required %0d", cnt, FRAME);
    end
    compared++;
    if (frameCount != base + 1) begin
      mismatched++;
      $display("[TB] FAIL single_frames: observed %0d, required %0d", frameCount, base + 1);
    end
    busWrite(A_ACK, 32'h0);
    compared++;
    if (UartInterrupt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_ack: observed irq %b, required 0", UartInterrupt);
    end
  endtask

  task automatic test_ack_race();
    expQ.push_back(8'h3C);
    busWrite(A_DATA, 32'h0000_003C);
    repeat (FRAME) @(negedge clk);
    compared++;
    if (UartInterrupt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL race_pre: observed irq %b, required 0", UartInterrupt);
    end
    busWrite(A_ACK, 32'h1234_5678);
    compared++;
    if (UartInterrupt !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL race_setwins: observed irq %b, required 1", UartInterrupt);
    end
    busWrite(A_ACK, 32'h0);
    compared++;
    if (UartInterrupt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL race_second_ack: observed irq %b, required 0", UartInterrupt);
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs[6];
    logic        hits[6];
    logic [31:0] rd;
    int          base;
    addrs = '{32'hffff_0040, 32'hffff_0044, 32'hffff_0048, 32'hffff_004c, 32'h0000_0040, 32'hffff_0050};
    hits  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      address = addrs[i];
      #1;
      compared++;
      if (UartAddress !== hits[i]) begin
        mismatched++;
        $display("[TB] FAIL decode_%h: observed %b, required %b", addrs[i], UartAddress, hits[i]);
      end
    end
    address = '0;
    busRead(A_DATA, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL read_data_addr: observed %h, required 00000000", rd);
    end
    busRead(A_ACK, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL read_ack_addr: observed %h, required 00000000", rd);
    end
    base = frameCount;
    busWrite(A_STATUS, 32'h0000_00FF);
    busWrite(32'hffff_004c, 32'h0000_0077);
    repeat (2 * FRAME) @(negedge clk);
    compared++;
    if (frameCount != base) begin
      mismatched++;
      $display("[TB] FAIL ignored_writes: observed %0d frames, required %0d", frameCount, base);
    end
    busRead(A_STATUS, rd);
    compared++;
    if (rd !== 32'h0000_0002) begin
      mismatched++;
      $display("[TB] FAIL ignored_status: observed %h, required 00000002", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] st;
    int          base;
    int          cnt;
    int          n;
    base = frameCount;
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    expQ.push_back(8'h33);
    busWrite(A_DATA, 32'h11);
    busWrite(A_DATA, 32'h22);
    busWrite(A_DATA, 32'h33);
    busRead(A_STATUS, st);
    compared++;
    if (st !== 32'h0000_0201) begin
      mismatched++;
      $display("[TB] FAIL b2b_status: observed %h, required 00000201", st);
    end
    cnt = 0;
    while (UartInterrupt !== 1'b1 && cnt < 3 * FRAME + 40) begin
      @(negedge clk);
      cnt++;
    end
    compared++;
    if (frameCount != base + 3) begin
      mismatched++;
      $display("[TB] FAIL b2b_frames_at_irq: observed %0d, required %0d", frameCount, base + 3);
    end
    n = frameStart.size();
    if (n >= 3) begin
      for (int i = n - 2; i < n; i++) begin
        compared++;
        if (frameStart[i] - frameStart[i-1] != FRAME) begin
          mismatched++;
          $display("[TB] FAIL b2b_gap: observed %0d cycles between starts, required %0d",
                   frameStart[i] - frameStart[i-1], FRAME);
        end
      end
    end
    busWrite(A_ACK, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] st;
    int          base;
    int          cnt;
    base = frameCount;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expQ.push_back(8'(8'h50 + i));
      busWrite(A_DATA, 32'(8'h50 + i));
    end
    busRead(A_STATUS, st);
    compared++;
    if (st !== 32'h0000_080D) begin
      mismatched++;
      $display("[TB] FAIL ovf_status: observed %h, required 0000080D", st);
    end
    cnt = 0;
    while (UartInterrupt !== 1'b1 && cnt < 9 * FRAME + 50) begin
      @(negedge clk);
      cnt++;
    end
    compared++;
    if (frameCount != base + 9) begin
      mismatched++;
      $display("[TB] FAIL ovf_frames: observed %0d, required %0d", frameCount, base + 9);
    end
    busRead(A_STATUS, st);
    compared++;
    if (st !== 32'h0000_001A) begin
      mismatched++;
      $display("[TB] FAIL ovf_done_status: observed %h, required 0000001A", st);
    end
    busWrite(A_ACK, 32'h0);
    busRead(A_STATUS, st);
    compared++;
    if (st !== 32'h0000_0002) begin
      mismatched++;
      $display("[TB] FAIL ovf_ack_status: observed %h, required 00000002", st);
    end
  endtask

  task automatic test_reset_glitch();
    logic [31:0] st;
    int          base;
    base = frameCount;
    expQ.push_back(8'h96);
    busWrite(A_DATA, 32'h96);
    repeat (CPB + 3) @(negedge clk);
    busRead(A_STATUS, st);
    compared++;
    if (st !== 32'h0000_0003) begin
      mismatched++;
      $display("[TB] FAIL glitch_pre_status: observed %h, required 00000003", st);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (txd !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL glitch_txd: observed %b, required 1", txd);
    end
    busRead(A_STATUS, st);
    compared++;
    if (st !== 32'h0000_0002) begin
      mismatched++;
      $display("[TB] FAIL glitch_status: observed %h, required 00000002", st);
    end
    expQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    compared++;
    if (UartInterrupt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL glitch_irq: observed %b, required 0", UartInterrupt);
    end
    compared++;
    if (frameCount != base) begin
      mismatched++;
      $display("[TB] FAIL glitch_frames: observed %0d, required %0d", frameCount, base);
    end
  endtask

  initial begin
    $display("[TB] starting mmio_uart_tx bench");
    test_reset();
    test_single_byte();
    test_ack_race();
    test_decode();
    test_back_to_back();
    test_overflow();
    test_reset_glitch();
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: observed %0d bytes outstanding, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
